// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state codes and requester IDs for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_RDATA = 2'd3;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; the priority pointer lives in the caller.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      prio,
    output port_t      winner
);

    always_comb begin
        winner = PORT_A;
        if (req == 2'b11) begin
            winner = prio;
        end else if (req[1]) begin
            winner = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester front end for a 32x32 single-port memory with round-robin arbitration.
//  state   | meaning
//  S_IDLE  | sample requests, latch winner's command
//  S_WRITE | write enable and winner's grant on the memory bus
//  S_READ  | read enable and winner's grant on the memory bus
//  S_RDATA | memory data valid; capture into winner's rdata
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    logic [1:0]        state;
    port_t             prio;
    port_t             win;
    port_t             winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter2 u_rr (
        .req    ({b_req, a_req}),
        .prio   (prio),
        .winner (winner)
    );

    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (winner == PORT_B) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    // Outputs are computed from the next state so every pulse is registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            prio         <= PORT_A;
            win          <= PORT_A;
            a_gnt        <= 1'b0;
            b_gnt        <= 1'b0;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
            mem_address  <= '0;
            mem_data_in  <= '0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            busy         <= 1'b0;
        end else begin
            a_gnt        <= 1'b0;
            b_gnt        <= 1'b0;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (a_req || b_req) begin
                        win         <= winner;
                        prio        <= (winner == PORT_A) ? PORT_B : PORT_A;
                        mem_address <= sel_addr;
                        a_gnt       <= (winner == PORT_A);
                        b_gnt       <= (winner == PORT_B);
                        busy        <= 1'b1;
                        if (sel_we) begin
                            mem_data_in  <= sel_wdata;
                            mem_write_en <= 1'b1;
                            state        <= S_WRITE;
                        end else begin
                            mem_read_en <= 1'b1;
                            state       <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_READ: begin
                    state <= S_RDATA;
                end
                S_RDATA: begin
                    if (win == PORT_A) begin
                        a_rdata  <= mem_data_out;
                        a_rvalid <= 1'b1;
                    end else begin
                        b_rdata  <= mem_data_out;
                        b_rvalid <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL be clocked by a single clock and SHALL use a synchronous, active-high reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_req, b_req  input  1 each  access request from requester A / B; level, held until grant.
REQ-005 a_we, b_we  input  1 each  1 = write, 0 = read; valid while the matching req is high.
REQ-006 a_addr, b_addr  input  5 each  word address; valid while req is high.
REQ-007 a_wdata, b_wdata  input  32 each  write data; valid while req is high with we = 1.
REQ-008 a_gnt, b_gnt  output  1 each  one-cycle pulse: request accepted and issued to memory.
REQ-009 a_rvalid, b_rvalid  output  1 each  one-cycle pulse: rdata holds the read result.
REQ-010 a_rdata, b_rdata  output  32 each  read result; holds its value until the next read completes for that port.
REQ-011 mem_address  output  5  drives the address port of the 32x32 memory.
REQ-012 mem_data_in  output  32  drives the data_in port of the memory.
REQ-013 mem_read_en, mem_write_en  output  1 each  drive the memory enables.
REQ-014 mem_data_out  input  32  memory data_out; valid in the cycle after the cycle in which mem_read_en was high.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have four states: IDLE, WRITE, READ and RDATA.
REQ-018 IDLE transitions:
- no req: stay in IDLE.
- any req: latch the winner's we, addr and wdata; go to WRITE if we = 1, else READ.
REQ-019 WRITE SHALL last one cycle: mem_write_en = 1, latched addr/wdata on the mem bus, winner's gnt = 1; then IDLE.
REQ-020 READ SHALL last one cycle: mem_read_en = 1, latched addr, winner's gnt = 1; then RDATA.
REQ-021 RDATA SHALL last one cycle: capture mem_data_out into the winner's rdata, assert the winner's rvalid in the following cycle, then IDLE.
REQ-022 Latency, with req sampled in IDLE at edge k:
- gnt and the mem enable are high during cycle k+1.
- For a read, rvalid is high during cycle k+3.
- Throughput is one write per 2 cycles or one read per 3 cycles.
REQ-023 Arbitration SHALL be 2-way round-robin:
- Pointer prio resets to A.
- When both ports request in IDLE, the port named by prio wins.
- After any grant, prio points to the non-winning port.
- A lone requester always wins, and prio is still updated.
REQ-024 A req still high at the first IDLE sample after its gnt SHALL be treated as a new request.
REQ-025 The losing requester's req SHALL remain pending without loss and SHALL be served at the next IDLE sample if still high.
REQ-026 Outside the WRITE and READ states, mem_read_en and mem_write_en SHALL be 0, and they SHALL never be high together.
REQ-027 Outside their defined cycles, gnt and rvalid SHALL be 0, and at most one gnt SHALL be high per cycle.
REQ-028 The block SHALL pass addresses 0..31 unchanged; there is no wrap or offset arithmetic.

Reset
REQ-029 After a reset edge, the block SHALL be in IDLE with prio = A and all gnt, rvalid, mem enables and busy = 0.
REQ-030 After a reset edge, mem_address = 0, mem_data_in = 0, and a_rdata = b_rdata = 0.
REQ-031 Reset asserted mid-transaction SHALL abort it: no gnt/rvalid for the aborted access and enables low in the next cycle.
REQ-032 Reset SHALL take priority over all FSM transitions.

Structure
REQ-033 Package mem_arb_pkg SHALL hold ADDR_W = 5, DATA_W = 32, the state enumeration and the port-ID enum (PORT_A, PORT_B).
REQ-034 The round-robin choice SHALL be a sub-module rr_arbiter2, with inputs req[1:0] and prio and output winner; it is combinational, and prio is held in mem_arbiter.

Verification
REQ-035 Reset, then A writes 32'hAAC3B504 to addr 5'b10111 -> a_gnt and mem_write_en high in the same cycle, mem_address = 10111, mem_data_in = AAC3B504.
REQ-036 A reads addr 10111 after REQ-035 -> mem_read_en pulse, then a_rvalid two cycles later with a_rdata = 32'hAAC3B504.
REQ-037 A and B both request in the same IDLE cycle (A write 01101 / 32'hB3045DF5, B write 01001 / 32'h1EC65FC2) -> A granted first, B granted at the next IDLE sample, never both gnt in one cycle.
REQ-038 Both ports request continuously for 6 grants -> grants alternate B, A, B, A, B, A after an initial A win (prio toggles).
REQ-039 B issues a read of 11111 and reset is asserted during RDATA -> no b_rvalid, all outputs at their reset values next cycle, FSM in IDLE with prio = A.
REQ-040 A random 200-transaction mix against a reference memory model -> every rdata matches the last write to that address, and mem_read_en/mem_write_en are never high together.
